// File: rtl/fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared types for the instruction fetch front end: instruction-bus request
// and response, the fetch result handed to decode, and the fetch error codes.
// ----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        NOERROR        = 2'd0,
        INSTR_MISALIGN = 2'd1
    } fetch_err_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic            data_ok;
        logic [ILEN-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        fetch_err_t      error;
        logic            valid;
    } fetch_data_t;

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Circular buffer of DEPTH entries of type entry_t (DEPTH a power of two, so
// the head/tail pointers wrap naturally). No bypass: a pushed entry becomes
// visible at head one cycle later.
//   clk, reset : clock, synchronous active-high reset
//   push, data : enqueue data (ignored when full unless popping too)
//   pop        : dequeue head (ignored when empty)
//   clear      : drop all entries; overrides push and pop
//   full, empty: occupancy flags
//   head       : oldest entry
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t data,
    input  logic   pop,
    input  logic   clear,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  head_ptr;
    logic [AW-1:0]  tail_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign head    = mem[head_ptr];

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + AW'(1);
            if (do_pop)  head_ptr <= head_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, and count guards validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= data;
    end

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch unit: translates the PC, issues one instruction-bus read
// at a time and queues the results for decode. Redirects (flush has priority
// over branch) empty the queue and retire any in-flight handshake as stale.
//   clk, reset          : clock, synchronous active-high reset
//   flush, flush_pc     : CSR redirect and its target
//   branch, branch_pc   : execute redirect and its target
//   tr_req, tr_va       : translation request / virtual PC
//   tr_done, tr_pa      : translation complete / physical address
//   ireq, iresp         : instruction bus request / response
//   out_valid, out_ready: head-entry handshake with decode
//   out_data            : head entry (instr, pc, error, valid)
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [63:0] flush_pc,
    input  logic        branch,
    input  logic [63:0] branch_pc,
    output logic        tr_req,
    output logic [63:0] tr_va,
    input  logic        tr_done,
    input  logic [63:0] tr_pa,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t out_data
);

    typedef enum logic [1:0] {IDLE, XLATE, BUS, HALT} state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] pa;
    logic [63:0] req_va;
    logic        epoch;
    logic        req_epoch;
    logic        stale_q;

    logic        redirect;
    logic [63:0] redirect_pc;
    logic        inflight;
    logic        has_room;
    logic        stale;
    logic        resp_ok;
    logic        misalign_push;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    fetch_data_t push_entry;
    fetch_data_t head;

    assign redirect    = flush || branch;
    assign redirect_pc = flush ? flush_pc : branch_pc;

    // At most one transaction is ever outstanding and new ones start only
    // from IDLE, so count + inflight < DEPTH reduces to "not full, idle".
    assign inflight = (state == XLATE) || (state == BUS);
    assign has_room = !fifo_full && !inflight;

    // The epoch bit alone would alias after an even number of redirects
    // within one transaction; the sticky flag closes that hole.
    assign stale = stale_q || (req_epoch != epoch);

    assign resp_ok       = (state == BUS) && iresp.data_ok && !redirect && !stale;
    assign misalign_push = (state == IDLE) && !redirect && has_room && (pc[1:0] != 2'b00);
    assign push          = resp_ok || misalign_push;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        push_entry       = '0;
        push_entry.instr = misalign_push ? '0 : iresp.data;
        push_entry.pc    = pc;
        push_entry.error = misalign_push ? INSTR_MISALIGN : NOERROR;
        push_entry.valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            pa        <= '0;
            req_va    <= RESET_PC;
            epoch     <= 1'b0;
            req_epoch <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            if (redirect) begin
                pc    <= redirect_pc;
                epoch <= ~epoch;
            end else if (resp_ok) begin
                pc <= pc + 64'd4;
            end

            unique case (state)
                IDLE: begin
                    if (!redirect && has_room) begin
                        if (pc[1:0] != 2'b00) begin
                            state <= HALT;
                        end else begin
                            state     <= XLATE;
                            req_va    <= pc;
                            req_epoch <= epoch;
                            stale_q   <= 1'b0;
                        end
                    end
                end
                XLATE: begin
                    // A redirect keeps the request up until the translator
                    // answers, then the answer is dropped.
                    if (redirect) stale_q <= 1'b1;
                    if (tr_done) begin
                        if (redirect || stale) begin
                            state <= IDLE;
                        end else begin
                            pa    <= tr_pa;
                            state <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (redirect) stale_q <= 1'b1;
                    if (iresp.data_ok) state <= IDLE;
                end
                HALT: begin
                    if (redirect) state <= IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_data_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .data  (push_entry),
        .pop   (pop),
        .clear (redirect),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Gating with reset makes outputs quiet from the very first reset cycle.
    assign tr_req = !reset && (state == XLATE);
    assign tr_va  = req_va;

    always_comb begin
        ireq       = '0;
        ireq.valid = !reset && (state == BUS);
        ireq.addr  = pa;
    end

    assign out_valid = !reset && !fifo_empty && !redirect;
    assign pop       = out_valid && out_ready;

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data       = head;
            out_data.valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue. Inputs change and outputs are sampled on
// the falling edge; the translator maps va -> va + PA_OFF.
// ----------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam logic [63:0] PA_OFF   = 64'h0000_0010_0000_0000;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [63:0] flush_pc;
    logic        branch;
    logic [63:0] branch_pc;
    logic        tr_req;
    logic [63:0] tr_va;
    logic        tr_done;
    logic [63:0] tr_pa;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        out_valid;
    logic        out_ready;
    fetch_data_t out_data;

    int          n_cmp;
    int          n_err;
    logic [63:0] exp_pc;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .branch    (branch),
        .branch_pc (branch_pc),
        .tr_req    (tr_req),
        .tr_va     (tr_va),
        .tr_done   (tr_done),
        .tr_pa     (tr_pa),
        .ireq      (ireq),
        .iresp     (iresp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tr_req();
        int n = 0;
        while (!tr_req && n < 20) begin
            step();
            n++;
        end
        check("tr_req_wait", tr_req, 1'b1);
    endtask

    // One full translate + bus read at exp_pc returning instr.
    task automatic xact(input logic [31:0] instr);
        wait_tr_req();
        check("tr_va", tr_va, exp_pc);
        tr_done = 1'b1;
        tr_pa   = exp_pc + PA_OFF;
        step();
        tr_done = 1'b0;
        tr_pa   = '0;
        check("tr_req_drop", tr_req, 1'b0);
        check("ireq_valid", ireq.valid, 1'b1);
        check("ireq_addr", ireq.addr, exp_pc + PA_OFF);
        iresp.data_ok = 1'b1;
        iresp.data    = instr;
        step();
        iresp = '0;
        check("ireq_done", ireq.valid, 1'b0);
        exp_pc += 64'd4;
    endtask

    initial begin
        logic [31:0] instrs [5];
        instrs[0] = 32'hA0A0_0001;
        instrs[1] = 32'hB0B0_0002;
        instrs[2] = 32'hC0C0_0003;
        instrs[3] = 32'hD0D0_0004;
        instrs[4] = 32'hE0E0_0005;

        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        flush_pc  = '0;
        branch    = 1'b0;
        branch_pc = '0;
        tr_done   = 1'b0;
        tr_pa     = '0;
        iresp     = '0;
        out_ready = 1'b0;
        exp_pc    = RESET_PC;

        // Reset state
        step();
        check("rst_tr_req", tr_req, 1'b0);
        check("rst_ireq_valid", ireq.valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        step();
        reset = 1'b0;
        step();
        check("first_req", tr_req, 1'b1);

        // Fill the queue with out_ready low
        xact(instrs[0]);
        check("lat_out_valid", out_valid, 1'b1);
        for (int i = 1; i < 4; i++) xact(instrs[i]);
        for (int i = 0; i < 4; i++) begin
            step();
            check("full_no_tr_req", tr_req, 1'b0);
            check("full_no_ireq", ireq.valid, 1'b0);
        end
        check("head_a_pc", out_data.pc, 64'h8000_0000);
        check("head_a_instr", out_data.instr, instrs[0]);
        check("head_a_err", out_data.error, NOERROR);
        check("head_a_valid", out_data.valid, 1'b1);

        // One pop frees a slot for the fifth fetch
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("head_b_pc", out_data.pc, 64'h8000_0004);
        xact(instrs[4]);

        // Drain in order
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("drain_pc", out_data.pc, RESET_PC + 64'(4 * i));
            check("drain_instr", out_data.instr, instrs[i]);
            step();
        end
        check("drained", out_valid, 1'b0);

        // Streaming with out_ready high: at most one entry at a time
        for (int i = 0; i < 3; i++) begin
            xact(32'h1111_0000 + 32'(i));
            check("stream_valid", out_valid, 1'b1);
            check("stream_pc", out_data.pc, exp_pc - 64'd4);
            step();
            check("stream_empty", out_valid, 1'b0);
        end

        // Branch while in BUS; response two cycles later is dropped
        wait_tr_req();
        check("pre_branch_va", tr_va, 64'h8000_0020);
        tr_done = 1'b1;
        tr_pa   = 64'h8000_0020 + PA_OFF;
        step();
        tr_done = 1'b0;
        check("bus_before_branch", ireq.valid, 1'b1);
        branch    = 1'b1;
        branch_pc = 64'h8000_1000;
        step();
        branch = 1'b0;
        check("bus_held", ireq.valid, 1'b1);
        check("bus_held_addr", ireq.addr, 64'h8000_0020 + PA_OFF);
        step();
        iresp.data_ok = 1'b1;
        iresp.data    = 32'hDEAD_BEEF;
        step();
        iresp = '0;
        check("stale_dropped", out_valid, 1'b0);
        check("stale_bus_idle", ireq.valid, 1'b0);
        exp_pc = 64'h8000_1000;
        xact(32'h2222_0001);
        check("after_branch_pc", out_data.pc, 64'h8000_1000);
        step();
        out_ready = 1'b0;
        check("after_branch_pop", out_valid, 1'b0);

        // Flush and branch together; flush target wins
        xact(32'h3333_0001);
        wait_tr_req();
        check("pre_flush_valid", out_valid, 1'b1);
        flush     = 1'b1;
        flush_pc  = 64'h8000_2000;
        branch    = 1'b1;
        branch_pc = 64'h8000_3000;
        #1;
        check("redirect_masks_valid", out_valid, 1'b0);
        check("redirect_masks_data", out_data.valid, 1'b0);
        step();
        flush  = 1'b0;
        branch = 1'b0;
        check("flush_cleared", out_valid, 1'b0);
        check("xlate_held", tr_req, 1'b1);
        tr_done = 1'b1;
        tr_pa   = 64'h1234_0000;
        step();
        tr_done = 1'b0;
        tr_pa   = '0;
        check("stale_xlate_no_bus", ireq.valid, 1'b0);
        exp_pc = 64'h8000_2000;
        xact(32'h4444_0001);
        wait_tr_req();

        // Branch to a misaligned PC
        branch    = 1'b1;
        branch_pc = 64'h8000_0002;
        step();
        branch  = 1'b0;
        tr_done = 1'b1;
        step();
        tr_done = 1'b0;
        check("mis_no_tr", tr_req, 1'b0);
        check("mis_q_empty", out_valid, 1'b0);
        step();
        check("mis_valid", out_valid, 1'b1);
        check("mis_pc", out_data.pc, 64'h8000_0002);
        check("mis_err", out_data.error, INSTR_MISALIGN);
        check("mis_instr", out_data.instr, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("mis_single", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("halt_no_tr", tr_req, 1'b0);
            check("halt_no_ireq", ireq.valid, 1'b0);
            check("halt_no_entry", out_valid, 1'b0);
            step();
        end
        branch    = 1'b1;
        branch_pc = 64'h8000_0100;
        step();
        branch = 1'b0;
        exp_pc = 64'h8000_0100;
        xact(32'h5555_0001);

        // Reset in XLATE
        wait_tr_req();
        check("pre_rst_valid", out_valid, 1'b1);
        reset = 1'b1;
        step();
        check("mid_rst_tr_req", tr_req, 1'b0);
        check("mid_rst_ireq", ireq.valid, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, '0);
        reset = 1'b0;
        step();
        check("post_rst_tr_req", tr_req, 1'b1);
        check("post_rst_va", tr_va, RESET_PC);
        check("post_rst_empty", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the instruction-queue entries; power of two, at least 2.
REQ-002 The block SHALL have parameter RESET_PC, default 64'h8000_0000, giving the PC loaded on reset.
REQ-003 The block SHALL have the following ports, with clk and reset first:
- clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
- flush  in  1  CSR redirect (trap, mret, ecall return).
- flush_pc  in  64  target for flush.
- branch  in  1  execute redirect.
- branch_pc  in  64  target for branch.
- tr_req  out  1  translation request.
- tr_va  out  64  virtual PC.
- tr_done  in  1  translation complete.
- tr_pa  in  64  physical address, valid with tr_done.
- ireq  out  ibus_req_t  instruction bus request.
- iresp  in  ibus_resp_t  instruction bus response.
- out_valid  out  1  head entry valid; out_ready  in  1  decode accepts.
- out_data  out  fetch_data_t  head entry: instr, pc, error, valid.

Function
REQ-004 The PC register SHALL update with priority reset > flush > branch > advance (PC+4 after a bus response is accepted) > hold.
REQ-005 The fetch FSM SHALL have states IDLE, XLATE, BUS and HALT.
REQ-006 IDLE -> XLATE SHALL occur when count + inflight < DEPTH and PC[1:0] == 0.
REQ-007 IDLE -> HALT SHALL occur when PC[1:0] != 0; one entry with error INSTR_MISALIGN and instr 0 SHALL be enqueued, with no bus or translation request.
REQ-008 In XLATE, tr_req SHALL be 1 and tr_va SHALL be PC; on tr_done the block SHALL latch tr_pa and go to BUS.
REQ-009 In BUS, ireq.valid SHALL be 1 and ireq.addr SHALL be the latched pa; on iresp.data_ok the block SHALL enqueue {instr, pc, NOERROR} and return to IDLE.
REQ-010 At most one bus transaction SHALL be outstanding at a time.
REQ-011 HALT SHALL be left only by flush or branch.
REQ-012 Flush or branch SHALL, in the same cycle:
- empty the queue;
- load the new PC;
- toggle an epoch bit.
REQ-013 If a redirect occurs in XLATE or BUS, the FSM SHALL hold its request until tr_done or data_ok completes that handshake.
- The completed result SHALL be discarded as stale (epoch mismatch).
- It SHALL NOT be enqueued, and the FSM then goes to IDLE.
REQ-014 A redirect arriving in the same cycle as data_ok SHALL win; the response is discarded.
REQ-015 The queue SHALL be a circular buffer with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-016 Enqueue and dequeue in the same cycle SHALL leave count unchanged; this is legal when full and when empty.
- When empty, there is no bypass: a response becomes visible the next cycle.
REQ-017 Enqueue SHALL be suppressed when full; REQ-006 guarantees this never drops data.
REQ-018 out_valid SHALL be (count != 0) and not flush and not branch; out_data SHALL be the head entry, and out_data.valid SHALL equal out_valid.
REQ-019 Dequeue SHALL occur on out_valid && out_ready.
REQ-020 Latency SHALL be tr_done-to-bus 1 cycle and data_ok-to-out_valid 1 cycle.
REQ-021 A translation that hits on the first cycle SHALL give a minimum of 3 cycles from IDLE to out_valid.

Reset
REQ-022 During reset the block SHALL set:
- PC = RESET_PC; FSM = IDLE; queue empty; epoch = 0;
- tr_req = 0, ireq.valid = 0, out_valid = 0, out_data = 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction immediately; the bus and translator are reset by the same signal.
REQ-024 The first request after reset SHALL be issued in the cycle after reset deasserts.

Structure
REQ-025 ibus_req_t, ibus_resp_t, fetch_data_t and the error encodings (NOERROR, INSTR_MISALIGN) SHALL stay in the shared common and pipes packages.
REQ-026 The fetch FSM state enum SHALL be local to the module.
REQ-027 The circular buffer SHALL be the sub-module fetch_fifo, parametrised by DEPTH and entry type, with ports push, pop, clear, full, empty and head.

Verification
REQ-028 Reset, then tr_done and data_ok returning instrs A, B, C, D, E with out_ready=0 -> 4 entries (pc 0x80000000..0x8000000C) and a full queue; no 5th ireq until the first pop.
REQ-029 With out_ready=1 throughout -> pcs step by 4 in order, and count never exceeds 1 after the first entry.
REQ-030 Branch to 0x80001000 while in BUS, with data_ok two cycles later -> that response is dropped, the queue is empty, and the next ireq.addr = pa(0x80001000).
REQ-031 Flush and branch in the same cycle -> PC = flush_pc.
REQ-032 Branch to 0x80000002 -> one entry with INSTR_MISALIGN and pc 0x80000002, no ireq, and the FSM stays in HALT until the next redirect.
REQ-033 Reset asserted in XLATE -> tr_req = 0 next cycle, PC = RESET_PC, and out_valid = 0.
